uart_bus_responder: RTL and testbench

- Memory-mapped UART responder on the single-cycle CPU's data bus (addr/rd/wr/wdata/rdata), decoded in the 0x4000_xxxx peripheral space.
- Serialises bytes written by the CPU onto UART_TX and deserialises UART_RX into a readable holding register.
- Raises irqout on TX-complete or RX-ready, gated by per-source enables, for the CPU's interrupt path.
- Format is fixed 8N1, LSB first.

---
 rtl/uart_bus_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_bus_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_bus_responder.sv
// Memory-mapped 8N1 UART responder on the CPU data bus.
// Ports:
//   sysclk, reset     : clock (rising edge) and async active-low reset
//   rd, wr, addr      : bus strobes and byte address (exact-match decode)
//   wdata, rdata      : write data in, combinational read data out
//   UART_RX, UART_TX  : serial input (asynchronous) and output
//   irqout            : level interrupt, TX-complete / RX-ready gated by enables
module uart_bus_responder #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 9600,
    parameter logic [31:0] BASE   = 32'h4000_0018
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irqout
);

    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);

    localparam logic [31:0]      ADDR_TXD = BASE;
    localparam logic [31:0]      ADDR_RXD = BASE + 32'd4;
    localparam logic [31:0]      ADDR_CON = BASE + 32'd8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e             tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]         tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]         tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               tx_line_q, tx_line_d;
    logic               tx_ie_q, tx_ie_d, rx_ie_q, rx_ie_d;
    logic               tx_done_q, tx_done_d, rx_ready_q, rx_ready_d;
    logic               overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic               irq_q, irq_d;
    logic               rx_s1_q, rx_s2_q, rx_s3_q;
    logic               tx_done_set, rx_good, rx_bad;
    logic               wdata_unused;

    // Bus decode
    logic wr_txd, wr_con, rd_rxd, rd_con, tx_busy;
    assign wr_txd  = wr && (addr == ADDR_TXD);
    assign wr_con  = wr && (addr == ADDR_CON);
    assign rd_rxd  = rd && (addr == ADDR_RXD);
    assign rd_con  = rd && (addr == ADDR_CON);
    assign tx_busy = (tx_state_q != S_IDLE);
    assign wdata_unused = ^wdata[31:8];

    logic tx_cnt_last, tx_bit_last, rx_cnt_last, rx_cnt_half, rx_bit_last, rx_fall;
    assign tx_cnt_last = (tx_cnt_q == CNT_LAST);
    assign tx_bit_last = (tx_bit_q == 3'd7);
    assign rx_cnt_last = (rx_cnt_q == CNT_LAST);
    assign rx_cnt_half = (rx_cnt_q == CNT_HALF);
    assign rx_bit_last = (rx_bit_q == 3'd7);
    assign rx_fall     = rx_s3_q && !rx_s2_q;

    // State registers
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= S_IDLE;
            rx_state_q <= S_IDLE;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
        end
    end

    // TX next state
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            S_IDLE:  if (wr_txd) tx_state_d = S_START;
            S_START: if (tx_cnt_last) tx_state_d = S_DATA;
            S_DATA:  if (tx_cnt_last && tx_bit_last) tx_state_d = S_STOP;
            S_STOP:  if (tx_cnt_last) tx_state_d = S_IDLE;
            default: tx_state_d = S_IDLE;
        endcase
    end

    // RX next state; the start bit is re-checked at its midpoint to reject glitches
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            S_IDLE:  if (rx_fall) rx_state_d = S_START;
            S_START: if (rx_cnt_half) rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            S_DATA:  if (rx_cnt_last && rx_bit_last) rx_state_d = S_STOP;
            S_STOP:  if (rx_cnt_last) rx_state_d = S_IDLE;
            default: rx_state_d = S_IDLE;
        endcase
    end

    // TX datapath: line is registered, next bit is preloaded at each bit boundary
    always_comb begin
        tx_cnt_d    = tx_cnt_q + 1'b1;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_line_d   = tx_line_q;
        tx_done_set = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (wr_txd) begin
                    tx_shift_d = wdata[7:0];
                    tx_bit_d   = 3'd0;
                    tx_line_d  = 1'b0;
                end
            end
            S_START: if (tx_cnt_last) begin
                tx_cnt_d  = '0;
                tx_line_d = tx_shift_q[0];
            end
            S_DATA: if (tx_cnt_last) begin
                tx_cnt_d   = '0;
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_shift_d = tx_shift_q >> 1;
                tx_line_d  = tx_bit_last ? 1'b1 : tx_shift_q[1];
            end
            S_STOP: if (tx_cnt_last) begin
                tx_cnt_d    = '0;
                tx_done_set = 1'b1;
            end
            default: tx_cnt_d = '0;
        endcase
    end

    // RX datapath
    always_comb begin
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_good    = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state_q)
            S_IDLE: rx_cnt_d = '0;
            S_START: if (rx_cnt_half) begin
                rx_cnt_d = '0;
                rx_bit_d = 3'd0;
            end
            S_DATA: if (rx_cnt_last) begin
                rx_cnt_d   = '0;
                rx_bit_d   = rx_bit_q + 3'd1;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            end
            S_STOP: if (rx_cnt_last) begin
                rx_cnt_d = '0;
                rx_good  = rx_s2_q;
                rx_bad   = !rx_s2_q;
            end
            default: rx_cnt_d = '0;
        endcase
    end

    // Status flags: a set event in the same cycle as a read-clear wins
    always_comb begin
        tx_ie_d     = wr_con ? wdata[0] : tx_ie_q;
        rx_ie_d     = wr_con ? wdata[1] : rx_ie_q;
        tx_done_d   = tx_done_set | (tx_done_q & !rd_con);
        frame_err_d = rx_bad | (frame_err_q & !rd_con);
        rx_ready_d  = rx_good | (rx_ready_q & !rd_rxd);
        overrun_d   = (rx_good & rx_ready_q) | (overrun_q & !rd_rxd);
        rx_data_d   = rx_good ? rx_shift_q : rx_data_q;
        irq_d       = (tx_ie_q & tx_done_q) | (rx_ie_q & rx_ready_q);
    end

    // Datapath registers; the synchroniser idles high to match the line
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_line_q   <= 1'b1;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            tx_ie_q     <= 1'b0;
            rx_ie_q     <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_ready_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
        end else begin
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_line_q   <= tx_line_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            tx_ie_q     <= tx_ie_d;
            rx_ie_q     <= rx_ie_d;
            tx_done_q   <= tx_done_d;
            rx_ready_q  <= rx_ready_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
            rx_s1_q     <= UART_RX;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
        end
    end

    // Combinational read mux
    always_comb begin
        rdata = 32'h0;
        if (rd_rxd) begin
            rdata = {24'h0, rx_data_q};
        end else if (rd_con) begin
            rdata = {25'h0, frame_err_q, overrun_q, tx_busy, rx_ready_q,
                     tx_done_q, rx_ie_q, tx_ie_q};
        end
    end

    assign UART_TX = tx_line_q;
    assign irqout  = irq_q;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder at DIV=16 (CLK_HZ=160, BAUD=10).
module tb_uart_bus_responder;

    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] CON  = BASE + 32'd8;

    logic        sysclk = 1'b0;
    logic        reset, rd, wr, UART_RX, UART_TX, irqout;
    logic [31:0] addr, wdata, rdata;
    logic [31:0] v;
    int          total = 0;
    int          bad   = 0;

    always #5 sysclk = ~sysclk;

    uart_bus_responder #(.CLK_HZ(160), .BAUD(10), .BASE(BASE)) dut (
        .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .UART_RX(UART_RX), .UART_TX(UART_TX),
        .irqout(irqout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    // Read without crossing a clock edge: no side effects
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        #1;
        d = rdata;
        rd = 1'b0; addr = '0;
    endtask

    // Read held across one edge so the read side effects take place
    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        #1;
        d = rdata;
        tick();
        rd = 1'b0; addr = '0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        UART_RX = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (16) tick();
        end
        UART_RX = stop;
        repeat (16) tick();
        UART_RX = 1'b1;
    endtask

    initial begin
        logic [9:0] fr;
        logic       seen_low;
        int         n;

        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; UART_RX = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("por_tx", 32'(UART_TX), 32'h1);
        chk("por_irq", 32'(irqout), 32'h0);
        peek(CON, v); chk("por_con", v, 32'h0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // CON write keeps only the enable bits; unmapped accesses do nothing
        bus_wr(CON, 32'hFF);
        peek(CON, v); chk("con_wmask", v, 32'h03);
        bus_wr(BASE + 32'd12, 32'h0);
        peek(CON, v); chk("unmapped_wr", v, 32'h03);
        peek(BASE + 32'd12, v); chk("unmapped_rd", v, 32'h0);
        peek(TXD, v); chk("txd_rd", v, 32'h0);

        // Reset in the middle of a frame
        bus_wr(TXD, 32'h00);
        repeat (20) tick();
        chk("mid_tx_low", 32'(UART_TX), 32'h0);
        peek(CON, v); chk("mid_tx_con", v, 32'h13);
        reset = 1'b0;
        #1;
        chk("rst_tx", 32'(UART_TX), 32'h1);
        chk("rst_irq", 32'(irqout), 32'h0);
        peek(CON, v); chk("rst_con", v, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Transmit 0xA5 with a write of 0xFF while busy
        bus_wr(CON, 32'h1);
        bus_wr(TXD, 32'hA5);
        bus_wr(TXD, 32'hFF);
        n  = 1;
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            while (n < 8 + 16 * i) begin tick(); n++; end
            chk($sformatf("tx_bit%0d", i), 32'(UART_TX), 32'(fr[i]));
            if (i == 0) begin
                peek(CON, v); chk("tx_busy_on", v, 32'h11);
            end
        end
        while (n < 159) begin tick(); n++; end
        peek(CON, v); chk("tx_busy_last", v, 32'h11);
        tick();
        peek(CON, v); chk("tx_done_con", v, 32'h05);
        chk("tx_irq_lag", 32'(irqout), 32'h0);
        tick();
        chk("tx_irq", 32'(irqout), 32'h1);
        bus_rd(CON, v); chk("tx_con_rd", v, 32'h05);
        peek(CON, v); chk("tx_con_clr", v, 32'h01);
        tick();
        chk("tx_irq_clr", 32'(irqout), 32'h0);
        seen_low = 1'b0;
        repeat (200) begin
            tick();
            if (UART_TX == 1'b0) seen_low = 1'b1;
        end
        chk("tx_no_second", 32'(seen_low), 32'h0);

        // Receive 0x3C
        bus_wr(CON, 32'h2);
        send_rx(8'h3C, 1'b1);
        peek(CON, v); chk("rx_ready", v, 32'h0A);
        chk("rx_irq", 32'(irqout), 32'h1);
        bus_rd(RXD, v); chk("rx_data", v, 32'h3C);
        peek(CON, v); chk("rx_clr", v, 32'h02);
        tick();
        chk("rx_irq_clr", 32'(irqout), 32'h0);

        // Overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        peek(CON, v); chk("ovr_con", v, 32'h2A);
        bus_rd(RXD, v); chk("ovr_data", v, 32'h22);
        peek(CON, v); chk("ovr_clr", v, 32'h02);

        // Short start pulse is rejected
        UART_RX = 1'b0;
        repeat (4) tick();
        UART_RX = 1'b1;
        repeat (40) tick();
        peek(CON, v); chk("glitch_con", v, 32'h02);
        chk("glitch_irq", 32'(irqout), 32'h0);

        // Framing error leaves the held byte and ready flag alone
        send_rx(8'h77, 1'b1);
        send_rx(8'h55, 1'b0);
        peek(CON, v); chk("ferr_con", v, 32'h4A);
        peek(RXD, v); chk("ferr_data", v, 32'h77);
        bus_rd(CON, v); chk("ferr_rd", v, 32'h4A);
        peek(CON, v); chk("ferr_clr", v, 32'h0A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
